// File: rtl/divu64_seq.sv
// Sequential unsigned divider: one restoring step per cycle, XLEN iterations,
// with a single-cycle bypass for a zero divisor (RISC-V divu/remu results).
module divu64_seq #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            div_by_zero,
    output logic            z_flag
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   div_reg;
    logic [XLEN-1:0]   q_reg;
    logic [XLEN-1:0]   rem_reg;
    logic [CW-1:0]     count;

    logic [XLEN:0]     shifted;
    logic [XLEN:0]     trial;
    logic              no_borrow;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   q_next;

    // The stored remainder is always below the divisor, so it fits in XLEN
    // bits; only the shifted value needs the extra top bit for the compare.
    always_comb begin
        shifted   = {rem_reg, q_reg[XLEN-1]};
        trial     = shifted - {1'b0, div_reg};
        no_borrow = ~trial[XLEN];
        rem_next  = no_borrow ? trial[XLEN-1:0] : shifted[XLEN-1:0];
        q_next    = {q_reg[XLEN-2:0], no_borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_reg     <= '0;
            q_reg       <= '0;
            rem_reg     <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            z_flag      <= 1'b1;
        end else begin
            case (state)
                IDLE, FIN: begin
                    if (start && divisor == '0) begin
                        state       <= FIN;
                        done        <= 1'b1;
                        quotient    <= '1;
                        remainder   <= dividend;
                        div_by_zero <= 1'b1;
                        z_flag      <= 1'b0;
                    end else if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        div_reg <= divisor;
                        q_reg   <= dividend;
                        rem_reg <= '0;
                        count   <= '0;
                    end else begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    rem_reg <= rem_next;
                    q_reg   <= q_next;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        state       <= FIN;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= rem_next;
                        div_by_zero <= 1'b0;
                        z_flag      <= (q_next == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divu64_seq.sv
// Randomized scoreboard bench for divu64_seq: the driver queues expected
// results from plain / and %, and a monitor checks each done pulse.
module tb_divu64_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [63:0] dividend = '0;
    logic [63:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic        div_by_zero;
    logic        z_flag;

    divu64_seq #(.XLEN(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .z_flag      (z_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        logic        dbz;
        int          c0;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_issued = 0;
    int   n_done = 0;
    int   n_discarded = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Waits for the divider to be free, presents one request, and queues the
    // architecturally expected result (RISC-V divide-by-zero semantics).
    task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b, output int c0);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL issue_timeout: busy stuck at %b, expected 0", busy);
            c0 = -1;
            return;
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        c0    = cyc;
        start = 1'b0;
        e.c0  = c0;
        if (b == 64'd0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        sb.push_back(e);
        n_issued++;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation,
    // including its latency and how long busy was high beforehand.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                n_done++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_fail++;
                    $display("[TB] FAIL extra_done: done=1 with no request pending, expected 0");
                end else begin
                    e = sb.pop_front();
                    check_output("quotient", quotient, e.q);
                    check_output("remainder", remainder, e.r);
                    check_output("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    check_output("z_flag", 64'(z_flag), 64'(e.q == 64'd0));
                    check_output("latency_edges", 64'(cyc - e.c0), e.dbz ? 64'd0 : 64'd64);
                    check_output("busy_cycles", 64'(busy_cnt), e.dbz ? 64'd0 : 64'd64);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        int c_a;
        int c_b;
        logic [63:0] a;
        logic [63:0] b;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_quotient", quotient, 64'd0);
        check_output("rst_remainder", remainder, 64'd0);
        check_output("rst_dbz", 64'(div_by_zero), 64'd0);
        check_output("rst_z_flag", 64'(z_flag), 64'd1);
        rst_n = 1'b1;

        $display("[TB] directed cases");
        apply_stimulus(64'd100, 64'd7, c_a);
        drain();
        apply_stimulus(64'd5, 64'd0, c_a);
        drain();
        apply_stimulus('1, 64'd1, c_a);
        drain();
        apply_stimulus(64'd3, '1, c_a);
        drain();

        // A start pulse mid-run must be ignored entirely.
        apply_stimulus(64'd100, 64'd7, c_a);
        repeat (10) @(negedge clk);
        start    = 1'b1;
        dividend = 64'd9;
        divisor  = 64'd2;
        @(posedge clk);
        #1 start = 1'b0;
        drain();

        // Back-to-back: the second request is taken while done is high.
        apply_stimulus(64'd100, 64'd7, c_a);
        apply_stimulus(64'd9, 64'd2, c_b);
        check_output("b2b_start_edge", 64'(c_b - c_a), 64'd65);
        drain();

        $display("[TB] reset during run");
        apply_stimulus(64'd100, 64'd7, c_a);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midrst_busy", 64'(busy), 64'd0);
        check_output("midrst_done", 64'(done), 64'd0);
        check_output("midrst_quotient", quotient, 64'd0);
        check_output("midrst_remainder", remainder, 64'd0);
        check_output("midrst_dbz", 64'(div_by_zero), 64'd0);
        check_output("midrst_z_flag", 64'(z_flag), 64'd1);
        n_discarded += sb.size();
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(64'd1000, 64'd10, c_a);
        drain();

        $display("[TB] random cases");
        for (int i = 0; i < 1000; i++) begin
            a = rand64() >> $urandom_range(0, 63);
            case ($urandom_range(0, 7))
                0:       b = 64'd0;
                1:       b = 64'd1;
                2:       b = a;
                3:       b = a + 64'd1;
                4:       b = rand64();
                default: b = rand64() >> $urandom_range(0, 63);
            endcase
            apply_stimulus(a, b, c_a);
        end
        drain();

        check_output("done_count", 64'(n_done), 64'(n_issued - n_discarded));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation time %0t exceeded, expected completion", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/divu64_seq.md
# divu64_seq

Multi-cycle unsigned 64-bit divider for the ALU's RV64M `divu`/`remu` path. It consumes operands from the execute stage and returns quotient and remainder after a fixed number of cycles through a start/busy/done handshake. Each iteration uses the same unsigned compare that the set-less-than-unsigned path uses: a trial subtract, where carry-out = 1 means no borrow, so the partial remainder is ≥ the divisor. The block runs one restoring step per cycle, so the execute stage must stall on `busy`.

## Interface

- `XLEN`, default 64: operand and result width. Width rules below are stated for the default; all scale with `XLEN`.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a divide; sampled only when `busy`=0.
- `dividend`  input  64  rs1, unsigned; sampled with an accepted `start`.
- `divisor`  input  64  rs2, unsigned; sampled with an accepted `start`.
- `busy`  output  1  high while a division is in progress.
- `done`  output  1  single-cycle pulse when results become valid.
- `quotient`  output  64  rs1 / rs2.
- `remainder`  output  64  rs1 % rs2.
- `div_by_zero`  output  1  high when the last accepted `divisor` was 0.
- `z_flag`  output  1  high when `quotient` == 0. Same zero-flag meaning as the other ALU units.

## Operation

- States:
  - IDLE: after reset.
  - RUN: iterating.
  - FIN: one cycle, drives `done`.
- IDLE/FIN → RUN: on the edge where `start`=1 and `divisor`≠0.
  - Latch the divisor into a 64-bit register.
  - Load the 64-bit quotient/shift register with `dividend`.
  - Clear the 65-bit partial remainder.
  - Set the 7-bit iteration counter to 0.
- IDLE/FIN → FIN: on the edge where `start`=1 and `divisor`=0. This is the zero bypass with RISC-V results:
  - `quotient` = all ones.
  - `remainder` = `dividend`.
  - `div_by_zero` = 1.
- RUN, each edge:
  - Shift the partial remainder left by one. Its LSB takes the quotient register's MSB.
  - Compute the trial = shifted remainder − {1'b0, divisor} in 65 bits.
  - If there is no borrow (trial bit 64 = 0), the partial remainder takes the trial and the shifted-in quotient LSB is 1. Otherwise the partial remainder keeps the shifted value and the quotient LSB is 0.
  - The counter increments.
- RUN → FIN: on the edge that completes iteration 64 (counter reaches 63 before the edge).
  - `quotient` ← quotient register.
  - `remainder` ← partial remainder[63:0].
  - `div_by_zero` ← 0.
- FIN → IDLE: next edge when `start`=0.
- `start` while `busy`=1 is ignored: no restart, no queuing, operands not resampled.
- `quotient`, `remainder`, `div_by_zero` and `z_flag` are registered. They hold their values from FIN until the next FIN; they do not change during RUN.
- The partial remainder is always < 2·divisor, so 65 bits never overflow.

## Timing

- Reset (`rst_n`=0, asynchronous, any state):
  - state = IDLE.
  - `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0.
  - `z_flag`=1, since quotient = 0.
  - An in-flight division is discarded.
- Reset deassertion takes effect at the next rising edge; `start` is honoured on the first edge with `rst_n`=1.
- `busy` = (state == RUN). It rises the cycle after the accepted `start` edge E0.
- Normal latency: `done` is high in the cycle after edge E64, i.e. 65 cycles from `start` sampled to `done`. `busy` is high for exactly 64 cycles.
- Zero-divisor latency: `done` is high in the cycle after E0. `busy` never rises.
- `done` is high for exactly one cycle per accepted `start`.
- Back-to-back: a `start` sampled during FIN (`done`=1) is accepted. The next RUN begins immediately with no idle cycle.
- No combinational path from inputs to outputs.

## Test plan

- 100 / 7:
  - `quotient`=14, `remainder`=2, `div_by_zero`=0, `z_flag`=0.
  - `busy` high 64 cycles, `done` pulse 65 cycles after `start`.
- 5 / 0:
  - `quotient`=0xFFFF_FFFF_FFFF_FFFF, `remainder`=5, `div_by_zero`=1.
  - `done` one cycle after `start`, `busy` stays 0.
- Extremes:
  - 0xFFFF_FFFF_FFFF_FFFF / 1 → `quotient`=all ones, `remainder`=0.
  - 3 / 0xFFFF_FFFF_FFFF_FFFF → `quotient`=0, `remainder`=3, `z_flag`=1. Exercises the full-width borrow.
- Protocol:
  - Pulse `start` with new operands (9 / 2) at cycle 10 of a running 100 / 7. Result is still 14 / 2.
  - A `start` of 9 / 2 held high during FIN is accepted back-to-back and yields 4 / 1.
- Reset:
  - Assert `rst_n`=0 mid-RUN (cycle 30). All outputs go to their reset values immediately (`z_flag`=1) with no `done`.
  - After release, 1000 / 10 → 100 / 0.
- Random:
  - 1000 random operand pairs, including divisor ∈ {0, 1, dividend, dividend+1}, checked against `/` and `%`.
  - Assert one `done` per accepted `start`.
